fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch and program-counter block. It produces `instruction_in` for `control_unit` and consumes that unit's `pc_control` and the datapath's `alu_zero` to select the next PC.
- It sits between instruction memory and the decode stage.
- Each instruction is presented for one execute window. At the end of that window the PC is updated.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
- ADDR_W, 32, PC and instruction-memory address width; fixed at 32 for the MIPS target.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- pc_control  input  3  next-PC select from control_unit: 000 seq, 001 jump, 010 jr, 011 branch.
- alu_zero  input  1  ALU zero flag for the current instruction.
- jr_target  input  32  register-file rs value, used for jr.
- hold  input  1  extends the execute window (datapath stall).
- imem_req  output  1  instruction-memory read request.
- imem_addr  output  32  fetch address; equals pc_out.
- imem_rdata  input  32  read data; valid when imem_ack is high.
- imem_ack  input  1  read-complete strobe.
- instruction_out  output  32  current instruction, to control_unit.instruction_in.
- instr_valid  output  1  instruction_out is live for execute.
- pc_out  output  32  address of the current instruction.
- pc_plus4  output  32  pc_out + 4; link value for jal.
- retire_count  output  32  number of instructions completed.
- err_pc_ctrl  output  1  sticky flag: pc_control was 1xx at retire.
- err_misalign  output  1  sticky flag: jr_target[1:0] was nonzero at a jr retire.

Behaviour:
- Reset values: pc_out = RESET_PC, instruction_out = 0 (sll nop), instr_valid = 0, imem_req = 0, retire_count = 0, both error flags = 0. State goes to FETCH on the first cycle after reset deasserts.
- Reset during any state abandons any outstanding request. An imem_ack that arrives while reset is high is ignored.
- State FETCH:
  - imem_req = 1 and imem_addr = pc_out, both held stable until imem_ack is sampled high.
  - On ack: instruction_out <= imem_rdata, go to EXEC.
  - A same-cycle ack (combinational memory) is legal.
- State EXEC:
  - instr_valid = 1 and imem_req = 0.
  - If hold = 1: stay in EXEC; PC, instruction and counter are unchanged.
  - If hold = 0 (retire): pc_out <= next_pc, retire_count += 1 (wraps at 2^32), go to FETCH.
  - Minimum throughput is 2 cycles per instruction.
- An imem_ack outside FETCH is ignored.
- Next-PC rules, evaluated at retire. Here op = instruction_out[31:26], and pc_plus4 is used throughout:
  - 000: pc_plus4.
  - 001: {pc_plus4[31:28], instruction_out[25:0], 2'b00}.
  - 010: {jr_target[31:2], 2'b00}. Set err_misalign if jr_target[1:0] != 0.
  - 011, op = 4 (beq): taken when alu_zero = 1.
  - 011, op = 5 (bne): taken when alu_zero = 0.
  - 011, taken target: pc_plus4 + (sign-extended imm16 << 2), modulo 2^32. Not taken: pc_plus4.
  - 011 with any other op: pc_plus4.
  - 1xx: pc_plus4, and set err_pc_ctrl.
- All address arithmetic is 32-bit and wraps: PC 32'hFFFF_FFFC advances to 0.
- Error flags clear only on reset.
- pc_plus4 is combinational from pc_out.

Decomposition:
- Shared package `cpu_pkg`:
  - PC_SEQ / PC_JUMP / PC_JR / PC_BRANCH = 3'b000 / 001 / 010 / 011.
  - Opcode constants OP_RTYPE = 0, OP_J = 2, OP_JAL = 3, OP_BEQ = 4, OP_BNE = 5.
  - Fetch state enum {FETCH, EXEC}.
  - control_unit adopts the same package.
- One sub-module, `next_pc_calc`, purely combinational:
  - Inputs: pc_out, instruction_out, pc_control, alu_zero, jr_target.
  - Outputs: next_pc, misalign, bad_ctrl.

Test Plan:
- Sequential fetch, zero-wait memory: reset, then 3 instructions with pc_control = 000 and hold = 0 → pc_out 0, 4, 8; instr_valid pulses every 2nd cycle; retire_count = 3.
- Wait states plus hold:
  - Ack delayed 3 cycles → imem_req and imem_addr stable for all 4 FETCH cycles.
  - Hold = 1 for 2 EXEC cycles → instruction_out unchanged and retire_count does not increment until hold drops.
- Branches at pc = 0x100, imm = 0xFFFE:
  - beq with alu_zero = 1 → next pc = 0xFC.
  - beq with alu_zero = 0 → 0x104.
  - bne with alu_zero = 0 → 0xFC.
- Jump and jr:
  - j at pc = 0x4000_0010, addr26 = 0x0000040 → next pc 0x4000_0100.
  - jr with jr_target = 0x0000_2002 → next pc 0x2000, err_misalign = 1.
- Illegal control and wrap:
  - pc_control = 3'b101 at pc = 0xFFFF_FFFC → next pc 0, err_pc_ctrl = 1.
  - Sticky flags hold until reset.
- Reset mid-fetch: assert reset while imem_req = 1 and ack pending → the next cycle shows pc_out = RESET_PC and instr_valid = 0; the late ack is ignored.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: next-PC select codes, opcodes and the fetch state type.
package cpu_pkg;

    // Next-PC select codes driven by control_unit
    localparam logic [2:0] PC_SEQ    = 3'b000;
    localparam logic [2:0] PC_JUMP   = 3'b001;
    localparam logic [2:0] PC_JR     = 3'b010;
    localparam logic [2:0] PC_BRANCH = 3'b011;

    // MIPS primary opcodes (instruction[31:26])
    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;

    // Fetch/execute sequencing
    typedef enum logic {
        FETCH = 1'b0,
        EXEC  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection for the instruction currently in execute.
module next_pc_calc
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc_out,
    input  logic [31:0]       instruction_out,
    input  logic [2:0]        pc_control,
    input  logic              alu_zero,
    input  logic [ADDR_W-1:0] jr_target,
    output logic [ADDR_W-1:0] next_pc,
    output logic              misalign,
    output logic              bad_ctrl
);

    logic [ADDR_W-1:0] seq_pc;
    logic [ADDR_W-1:0] branch_off;
    logic [5:0]        opcode;
    logic              taken;

    // Select the address of the next instruction from pc_control and the branch outcome
    always_comb begin
        // NOTE: every output gets a default first so no path through the case leaves a latch.
        next_pc    = '0;
        misalign   = 1'b0;
        bad_ctrl   = 1'b0;
        opcode     = instruction_out[31:26];
        seq_pc     = pc_out + ADDR_W'(4);
        branch_off = {{(ADDR_W-18){instruction_out[15]}}, instruction_out[15:0], 2'b00};
        taken      = ((opcode == OP_BEQ) &&  alu_zero) ||
                     ((opcode == OP_BNE) && !alu_zero);

        case (pc_control)
            PC_SEQ:    next_pc = seq_pc;
            PC_JUMP:   next_pc = {seq_pc[ADDR_W-1:ADDR_W-4], instruction_out[25:0], 2'b00};
            PC_JR: begin
                next_pc  = {jr_target[ADDR_W-1:2], 2'b00};
                misalign = |jr_target[1:0];
            end
            PC_BRANCH: next_pc = taken ? (seq_pc + branch_off) : seq_pc;
            default: begin
                // 1xx is not a defined select: fall through sequentially and flag it
                next_pc  = seq_pc;
                bad_ctrl = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch and program counter: fetches one instruction, holds it for
// one execute window, then advances the PC at retire.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        pc_control,
    input  logic              alu_zero,
    input  logic [ADDR_W-1:0] jr_target,
    input  logic              hold,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_ack,
    output logic [31:0]       instruction_out,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic [31:0]       retire_count,
    output logic              err_pc_ctrl,
    output logic              err_misalign
);

    fetch_state_e      state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [31:0]       instr_q;
    logic              valid_q;
    logic              req_q;
    logic [31:0]       count_q;
    logic              err_ctrl_q;
    logic              err_mis_q;

    logic [ADDR_W-1:0] next_pc_d;
    logic              misalign_d;
    logic              bad_ctrl_d;

    next_pc_calc #(
        .ADDR_W (ADDR_W)
    ) u_next_pc (
        .pc_out          (pc_q),
        .instruction_out (instr_q),
        .pc_control      (pc_control),
        .alu_zero        (alu_zero),
        .jr_target       (jr_target),
        .next_pc         (next_pc_d),
        .misalign        (misalign_d),
        .bad_ctrl        (bad_ctrl_d)
    );

    // Fetch/execute sequencer with registered outputs; reset abandons any pending fetch
    always_ff @(posedge clk) begin
        // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC[ADDR_W-1:0];
            instr_q    <= 32'h0000_0000;
            valid_q    <= 1'b0;
            req_q      <= 1'b0;
            count_q    <= 32'd0;
            err_ctrl_q <= 1'b0;
            err_mis_q  <= 1'b0;
        end else begin
            case (state_q)
                FETCH: begin
                    // The first cycle out of reset only raises the request; acks before it are ignored
                    if (!req_q) begin
                        req_q <= 1'b1;
                    end else if (imem_ack) begin
                        instr_q <= imem_rdata;
                        valid_q <= 1'b1;
                        req_q   <= 1'b0;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    if (!hold) begin
                        pc_q       <= next_pc_d;
                        count_q    <= count_q + 32'd1;
                        err_ctrl_q <= err_ctrl_q | bad_ctrl_d;
                        err_mis_q  <= err_mis_q  | misalign_d;
                        valid_q    <= 1'b0;
                        req_q      <= 1'b1;
                        state_q    <= FETCH;
                    end
                end
            endcase
        end
    end

    assign imem_req        = req_q;
    assign imem_addr       = pc_q;
    assign instruction_out = instr_q;
    assign instr_valid     = valid_q;
    assign pc_out          = pc_q;
    assign pc_plus4        = pc_q + ADDR_W'(4);
    assign retire_count    = count_q;
    assign err_pc_ctrl     = err_ctrl_q;
    assign err_misalign    = err_mis_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a transaction-level model predicts every output
// each cycle, and hand-computed PC targets pin the model at key points.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  pc_control;
    logic        alu_zero;
    logic [31:0] jr_target;
    logic        hold;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic [31:0] instruction_out;
    logic        instr_valid;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic [31:0] retire_count;
    logic        err_pc_ctrl;
    logic        err_misalign;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk             (clk),
        .reset           (reset),
        .pc_control      (pc_control),
        .alu_zero        (alu_zero),
        .jr_target       (jr_target),
        .hold            (hold),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .imem_ack        (imem_ack),
        .instruction_out (instruction_out),
        .instr_valid     (instr_valid),
        .pc_out          (pc_out),
        .pc_plus4        (pc_plus4),
        .retire_count    (retire_count),
        .err_pc_ctrl     (err_pc_ctrl),
        .err_misalign    (err_misalign)
    );

    int n_vec = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Next-PC rules written directly from the ISA: signed integer offset arithmetic
    function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] instr,
                                             input logic [2:0] ctl, input logic z,
                                             input logic [31:0] jrt);
        logic [31:0] seq;
        int          imm;
        bit          take;
        seq  = pc + 32'd4;
        imm  = int'($signed(instr[15:0]));
        take = (instr[31:26] == 6'd4 && z) || (instr[31:26] == 6'd5 && !z);
        if (ctl == 3'b001) return {seq[31:28], instr[25:0], 2'b00};
        if (ctl == 3'b010) return jrt & 32'hFFFF_FFFC;
        if (ctl == 3'b011 && take) return seq + 32'(imm * 4);
        return seq;
    endfunction

    // Model: 0 = just out of reset, 1 = waiting for memory, 2 = executing
    int          m_phase;
    logic [31:0] m_pc, m_instr, m_count;
    logic        m_valid, m_req, m_err_ctl, m_err_mis;

    always @(posedge clk) begin
        if (reset) begin
            m_phase = 0; m_pc = 32'h0; m_instr = 32'h0; m_count = 32'h0;
            m_valid = 1'b0; m_req = 1'b0; m_err_ctl = 1'b0; m_err_mis = 1'b0;
        end else if (m_phase == 0) begin
            m_req = 1'b1; m_phase = 1;
        end else if (m_phase == 1) begin
            if (imem_ack) begin
                m_instr = imem_rdata; m_valid = 1'b1; m_req = 1'b0; m_phase = 2;
            end
        end else if (!hold) begin
            if (pc_control[2]) m_err_ctl = 1'b1;
            if (pc_control == 3'b010 && jr_target[1:0] != 2'b00) m_err_mis = 1'b1;
            m_pc    = ref_next(m_pc, m_instr, pc_control, alu_zero, jr_target);
            m_count = m_count + 32'd1;
            m_valid = 1'b0; m_req = 1'b1; m_phase = 1;
        end
    end

    // Compare every output against the model away from the active edge
    always @(negedge clk) begin
        if (cmp_en) begin
            check("pc_out",          pc_out,                 m_pc);
            check("pc_plus4",        pc_plus4,               m_pc + 32'd4);
            check("imem_addr",       imem_addr,              m_pc);
            check("imem_req",        32'(imem_req),          32'(m_req));
            check("instr_valid",     32'(instr_valid),       32'(m_valid));
            check("instruction_out", instruction_out,        m_instr);
            check("retire_count",    retire_count,           m_count);
            check("err_pc_ctrl",     32'(err_pc_ctrl),       32'(m_err_ctl));
            check("err_misalign",    32'(err_misalign),      32'(m_err_mis));
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Serve one fetch with 'delay' wait cycles, then execute with 'hold_n' stall cycles
    task automatic run_instr(input logic [31:0] instr, input logic [2:0] ctl, input logic az,
                             input logic [31:0] jrt, input int delay, input int hold_n,
                             output logic [31:0] fetched_pc);
        int          budget;
        logic [31:0] i0, c0;
        budget = 0;
        while (!imem_req && budget < 20) begin
            step();
            budget++;
        end
        if (budget >= 20) check("req_timeout", 32'(imem_req), 32'd1);
        fetched_pc = imem_addr;
        imem_ack   = 1'b0;
        for (int d = 0; d < delay; d++) begin
            step();
            check("req_stable",  32'(imem_req), 32'd1);
            check("addr_stable", imem_addr,     fetched_pc);
        end
        imem_ack   = 1'b1;
        imem_rdata = instr;
        pc_control = ctl;
        alu_zero   = az;
        jr_target  = jrt;
        hold       = (hold_n > 0);
        step();
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        for (int h = 0; h < hold_n; h++) begin
            i0 = instruction_out;
            c0 = retire_count;
            step();
            check("hold_instr", instruction_out,   i0);
            check("hold_count", retire_count,      c0);
            check("hold_valid", 32'(instr_valid),  32'd1);
        end
        hold = 1'b0;
        step();
    endtask

    localparam logic [31:0] I_NOP  = 32'h0000_0000;
    localparam logic [31:0] I_ADD  = 32'h0022_1820;
    localparam logic [31:0] I_J100 = 32'h0800_0040;
    localparam logic [31:0] I_BEQ  = 32'h1000_FFFE;
    localparam logic [31:0] I_BNE  = 32'h1400_FFFE;
    localparam logic [31:0] I_JR   = 32'h0000_0008;

    logic [31:0] fpc;

    initial begin
        reset = 1'b1; pc_control = 3'b000; alu_zero = 1'b0; jr_target = 32'h0;
        hold = 1'b0; imem_rdata = 32'h0; imem_ack = 1'b0;
        step();
        cmp_en = 1'b1;
        step();
        check("rst_pc",    pc_out,            32'h0);
        check("rst_valid", 32'(instr_valid),  32'd0);
        check("rst_req",   32'(imem_req),     32'd0);
        check("rst_count", retire_count,      32'd0);
        reset = 1'b0;

        // Sequential, zero-wait memory
        run_instr(I_ADD, 3'b000, 1'b0, 32'h0, 0, 0, fpc); check("seq_pc0", fpc, 32'h0);
        run_instr(I_ADD, 3'b000, 1'b0, 32'h0, 0, 0, fpc); check("seq_pc1", fpc, 32'h4);
        run_instr(I_NOP, 3'b000, 1'b0, 32'h0, 0, 0, fpc); check("seq_pc2", fpc, 32'h8);
        check("seq_count", retire_count, 32'd3);

        // Wait states and execute stall
        run_instr(I_ADD, 3'b000, 1'b0, 32'h0, 3, 2, fpc); check("ws_pc", fpc, 32'hC);
        check("ws_count", retire_count, 32'd4);

        // Branches around 0x100
        run_instr(I_J100, 3'b001, 1'b0, 32'h0, 0, 0, fpc); check("j_0x100", pc_out, 32'h100);
        run_instr(I_BEQ,  3'b011, 1'b1, 32'h0, 0, 0, fpc); check("beq_taken", pc_out, 32'hFC);
        run_instr(I_J100, 3'b001, 1'b0, 32'h0, 0, 0, fpc); check("j_back1", pc_out, 32'h100);
        run_instr(I_BEQ,  3'b011, 1'b0, 32'h0, 1, 0, fpc); check("beq_not", pc_out, 32'h104);
        run_instr(I_J100, 3'b001, 1'b0, 32'h0, 0, 0, fpc); check("j_back2", pc_out, 32'h100);
        run_instr(I_BNE,  3'b011, 1'b0, 32'h0, 0, 1, fpc); check("bne_taken", pc_out, 32'hFC);
        run_instr(I_J100, 3'b001, 1'b0, 32'h0, 0, 0, fpc);
        run_instr(I_BNE,  3'b011, 1'b1, 32'h0, 0, 0, fpc); check("bne_not", pc_out, 32'h104);

        // Jump keeps the upper nibble; jr aligns and flags misalignment
        run_instr(I_JR,   3'b010, 1'b0, 32'h4000_0010, 0, 0, fpc); check("jr_aligned", pc_out, 32'h4000_0010);
        check("mis_clear", 32'(err_misalign), 32'd0);
        run_instr(I_J100, 3'b001, 1'b0, 32'h0, 0, 0, fpc); check("j_upper", pc_out, 32'h4000_0100);
        run_instr(I_JR,   3'b010, 1'b0, 32'h0000_2002, 0, 0, fpc); check("jr_mis_pc", pc_out, 32'h2000);
        check("mis_set", 32'(err_misalign), 32'd1);

        // Illegal control at the top of memory wraps to zero
        run_instr(I_JR,   3'b010, 1'b0, 32'hFFFF_FFFC, 0, 0, fpc); check("jr_top", pc_out, 32'hFFFF_FFFC);
        check("ctl_clear", 32'(err_pc_ctrl), 32'd0);
        run_instr(I_NOP,  3'b101, 1'b0, 32'h0, 0, 0, fpc); check("wrap_pc", pc_out, 32'h0);
        check("ctl_set", 32'(err_pc_ctrl), 32'd1);
        run_instr(I_J100, 3'b001, 1'b0, 32'h0, 0, 0, fpc); check("sticky_pc", pc_out, 32'h100);
        check("ctl_sticky", 32'(err_pc_ctrl),  32'd1);
        check("mis_sticky", 32'(err_misalign), 32'd1);
        pc_control = 3'b000;

        // Reset while a fetch is pending; ack during and right after reset is ignored
        check("pend_req", 32'(imem_req), 32'd1);
        step();
        reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        step();
        check("mid_rst_pc",    pc_out,           32'h0);
        check("mid_rst_valid", 32'(instr_valid), 32'd0);
        check("mid_rst_instr", instruction_out,  32'h0);
        reset = 1'b0;
        step();
        check("late_ack_instr", instruction_out,  32'h0);
        check("late_ack_valid", 32'(instr_valid), 32'd0);
        check("flags_cleared",  32'({err_pc_ctrl, err_misalign}), 32'd0);
        imem_ack = 1'b0;
        run_instr(I_ADD, 3'b000, 1'b0, 32'h0, 0, 0, fpc); check("post_rst_pc", pc_out, 32'h4);
        check("post_rst_count", retire_count, 32'd1);

        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
